// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer for a bank of N NAND SR latches: registered active-low pulse, quiet gap, readback.
// Build option: define SR_LATCH_CTRL_VERIFY_EN to add the CHECK state and the ERR readback result.
module sr_latch_ctrl #(
    parameter int N            = 8,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    localparam int IW          = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstbar,
    // Handshake: req_x is a valid that stays high with op_x/idx_x stable until ack_x;
    // ack_x is a one-cycle ready/accept pulse, and op_x/idx_x are captured on that grant.
    input  logic          req_a,
    input  logic          op_a,
    input  logic [IW-1:0] idx_a,
    output logic          ack_a,
    input  logic          req_b,
    input  logic          op_b,
    input  logic [IW-1:0] idx_b,
    output logic          ack_b,
    output logic [N-1:0]  sbar,
    output logic [N-1:0]  rbar,
    input  logic [N-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    dbg_state,
    output logic          dbg_qbit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          op_r, op_next;
    logic [IW-1:0] idx_r, idx_next;
    logic          ptr, ptr_next;
    logic          grant_a, grant_b;
    logic          finish;
    logic          err_next;
    logic [N-1:0]  sbar_next, rbar_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_next    = op_r;
        idx_next   = idx_r;
        ptr_next   = ptr;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                // ptr only matters on contention; a lone requester always wins
                if (req_a && (!req_b || !ptr)) begin
                    grant_a = 1'b1;
                end else if (req_b) begin
                    grant_b = 1'b1;
                end
                if (req_a && req_b) begin
                    ptr_next = ~ptr;
                end
                if (grant_a) begin
                    op_next  = op_a;
                    idx_next = idx_a;
                end else if (grant_b) begin
                    op_next  = op_b;
                    idx_next = idx_b;
                end
                if (grant_a || grant_b) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
`ifdef SR_LATCH_CTRL_VERIFY_EN
                    state_next = CHECK;
`else
                    state_next = IDLE;
                    finish     = 1'b1;
`endif
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            CHECK: begin
                state_next = IDLE;
`ifdef SR_LATCH_CTRL_VERIFY_EN
                finish     = 1'b1;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Drive lines are decoded from the next state so the pulse edge lines up with ACK
    always_comb begin
        sbar_next = '1;
        rbar_next = '1;
        if (state_next == PULSE) begin
            if (op_next) begin
                sbar_next[idx_next] = 1'b0;
            end else begin
                rbar_next[idx_next] = 1'b0;
            end
        end
    end

    always_comb begin
        err_next = 1'b0;
`ifdef SR_LATCH_CTRL_VERIFY_EN
        err_next = finish && (q[idx_r] != op_r);
`endif
    end

    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= 1'b0;
            idx_r <= '0;
            ptr   <= 1'b0;
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            sbar  <= '1;
            rbar  <= '1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            op_r  <= op_next;
            idx_r <= idx_next;
            ptr   <= ptr_next;
            ack_a <= grant_a;
            ack_b <= grant_b;
            done  <= finish;
            err   <= err_next;
            sbar  <= sbar_next;
            rbar  <= rbar_next;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign dbg_qbit  = q[idx_r];

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl with behavioural NAND latch models on sbar/rbar/q.
// Follows SR_LATCH_CTRL_VERIFY_EN for the CHECK-cycle timing and ERR expectations.
module tb_sr_latch_ctrl;

    localparam int N = 8;
    localparam int P = 4;
    localparam int G = 2;
`ifdef SR_LATCH_CTRL_VERIFY_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int W = 33;

    logic         clk = 1'b0;
    logic         rstbar = 1'b1;
    logic         req_a = 1'b0, op_a = 1'b0;
    logic [2:0]   idx_a = '0;
    logic         req_b = 1'b0, op_b = 1'b0;
    logic [2:0]   idx_b = '0;
    logic         ack_a, ack_b, busy, done, err, dbg_qbit;
    logic [N-1:0] sbar, rbar, q;
    logic [1:0]   dbg_state;

    logic [N-1:0] lq = '0;
    logic [N-1:0] stuck0 = '0;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    sr_latch_ctrl #(.N(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .rstbar(rstbar),
        .req_a(req_a), .op_a(op_a), .idx_a(idx_a), .ack_a(ack_a),
        .req_b(req_b), .op_b(op_b), .idx_b(idx_b), .ack_b(ack_b),
        .sbar(sbar), .rbar(rbar), .q(q),
        .busy(busy), .done(done), .err(err),
        .dbg_state(dbg_state), .dbg_qbit(dbg_qbit)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // NAND latch bank: set dominates only if the controller ever broke the invariant
    always @(sbar or rbar) begin
        for (int i = 0; i < N; i++) begin
            if (sbar[i] === 1'b0) lq[i] = 1'b1;
            else if (rbar[i] === 1'b0) lq[i] = 1'b0;
        end
    end
    assign q = lq & ~stuck0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // scoreboard / drive-line monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        check("drive_inv", (($countones(~{sbar, rbar}) <= 1) && ((~sbar & ~rbar) == '0)) ? 1 : 0, 1);
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spur_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_cyc", cyc, e[32:1]);
                check("done_err", {31'b0, err}, {31'b0, e[0]});
            end
        end
    end

    task automatic wait_ack(input bit is_b, output int c);
        c = -1;
        for (int k = 0; k < 40 && c < 0; k++) begin
            @(negedge clk);
            if ((is_b ? ack_b : ack_a) === 1'b1) c = cyc;
        end
        if (c < 0) check("ack_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic push_exp(input int ack_cyc, input logic e_err);
        logic [31:0] dc;
        dc = 32'(ack_cyc + P + G + CHK);
        exp_q.push_back({dc, e_err});
    endtask

    task automatic issue_a(input logic op, input logic [2:0] idx, input logic e_err);
        int t0, c;
        @(negedge clk);
        req_a = 1'b1; op_a = op; idx_a = idx;
        t0 = cyc;
        wait_ack(1'b0, c);
        req_a = 1'b0;
        check("ack_lat", c - t0, 1);
        push_exp(c, e_err);
    endtask

    initial begin
        int t0, ca, cb, prev, d0;
        logic opv;

        // 1: asynchronous reset, checked right after the edge and while held
        #2 rstbar = 1'b0;
        #1;
        check("rst_sbar", sbar, 8'hFF);
        check("rst_rbar", rbar, 8'hFF);
        check("rst_ctl", {ack_a, ack_b, done, err, busy}, 5'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold", {sbar, rbar, ack_a, ack_b, done, err, busy}, {16'hFFFF, 5'b0});
        end
        rstbar = 1'b1;
        @(negedge clk);

        // 2: set latch 3 with cycle-by-cycle drive checks
        req_a = 1'b1; op_a = 1'b1; idx_a = 3'd3;
        t0 = cyc;
        push_exp(t0 + 1, 1'b0);
        for (int k = 1; k <= P + G + 1 + CHK; k++) begin
            @(negedge clk);
            check("set_ack", {31'b0, ack_a}, (k == 1) ? 1 : 0);
            if (k == 1) req_a = 1'b0;
            check("set_sbar", sbar, (k <= P) ? 8'hF7 : 8'hFF);
            check("set_rbar", rbar, 8'hFF);
            check("set_busy", {31'b0, busy}, (k <= P + G + CHK) ? 1 : 0);
        end
        wait_drain();
        check("q3", {31'b0, q[3]}, 1);

        // 3: contention on latch 1, A set then B reset
        req_a = 1'b1; op_a = 1'b1; idx_a = 3'd1;
        req_b = 1'b1; op_b = 1'b0; idx_b = 3'd1;
        t0 = cyc;
        wait_ack(1'b0, ca);
        req_a = 1'b0;
        check("rr_a_lat", ca - t0, 1);
        push_exp(ca, 1'b0);
        wait_ack(1'b1, cb);
        req_b = 1'b0;
        check("rr_b_gap", cb - ca, P + G + 1 + CHK);
        push_exp(cb, 1'b0);
        wait_drain();
        check("q1_final", {31'b0, q[1]}, 0);

        // 4: latch 5 stuck at 0
        stuck0 = 8'h20;
        issue_a(1'b1, 3'd5, (CHK == 1) ? 1'b1 : 1'b0);
        wait_drain();
        stuck0 = '0;

        // 5: reset dropped in cycle 2 of a pulse
        d0 = done_cnt;
        @(negedge clk);
        req_a = 1'b1; op_a = 1'b1; idx_a = 3'd6;
        t0 = cyc;
        wait_ack(1'b0, ca);
        req_a = 1'b0;
        check("rst5_ack", ca - t0, 1);
        @(negedge clk);
        check("rst5_pulse", sbar, 8'hBF);
        #1 rstbar = 1'b0;
        #1;
        check("rst5_sbar", sbar, 8'hFF);
        check("rst5_rbar", rbar, 8'hFF);
        check("rst5_busy", {31'b0, busy}, 0);
        check("rst5_state", {30'b0, dbg_state}, 0);
        repeat (2) @(negedge clk);
        rstbar = 1'b1;
        repeat (P + G + 6) @(negedge clk);
        check("rst5_nodone", done_cnt - d0, 0);

        // 6: req_b held with alternating op on latch 2
        opv = 1'($urandom_range(0, 1));
        req_b = 1'b1; op_b = opv; idx_b = 3'd2;
        prev = -1;
        for (int n = 0; n < 4; n++) begin
            wait_ack(1'b1, cb);
            if (n == 3) req_b = 1'b0;
            if (prev >= 0) check("b_interval", cb - prev, P + G + 1 + CHK);
            push_exp(cb, 1'b0);
            prev = cb;
            opv = ~opv;
            op_b = opv;
        end
        wait_drain();
        check("q2_final", {31'b0, q[2]}, {31'b0, ~opv});

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Sequencer and arbiter for a bank of N cross-coupled NAND SR latches with active-low set/reset inputs. Two requesters issue set or reset commands against a latch index. The block grants them round-robin and drives a registered, glitch-free active-low pulse of fixed width on exactly one latch input. It then enforces a quiet gap and reads the latch Q back to confirm the write. It is the only driver of the bank's SBAR/RBAR nets, so the forbidden SBAR=RBAR=0 condition cannot occur.

## Interface
- N, 8: number of latches in the bank; legal values 2, 4, 8, 16; IW = $clog2(N).
- PULSE_CYCLES, 4: width of the active-low set/reset pulse in CLK cycles; must be ≥1.
- GAP_CYCLES, 2: all-inputs-high settle time after the pulse; must be ≥1.
- CLK  input  1  single clock, rising edge.
- RSTBAR  input  1  reset, asynchronous, active-low.
- REQ_A / REQ_B  input  1  command request; held until the matching ACK.
- OP_A / OP_B  input  1  1 = set (Q→1), 0 = reset (Q→0); stable while REQ is high.
- IDX_A / IDX_B  input  IW  target latch; stable while REQ is high.
- ACK_A / ACK_B  output  1  one-cycle grant pulse.
- SBAR  output  N  active-low set lines to latch bank; registered.
- RBAR  output  N  active-low reset lines to latch bank; registered.
- Q  input  N  latch outputs, read back.
- BUSY  output  1  high in all states other than IDLE.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  valid only with DONE; 1 = readback mismatch.

## Operation
- Reset values: SBAR and RBAR all 1s; ACK_A, ACK_B, DONE, ERR and BUSY all 0; state IDLE; round-robin pointer set to A.
- Latch contents are not affected by reset. Releasing pulses only stops the drive.
- FSM states: IDLE → PULSE → GAP → CHECK → IDLE.
- IDLE:
  - If only one REQ is high, that requester is granted.
  - If both are high, the pointer's requester is granted, and the pointer then moves to the other requester.
  - A single requester is never blocked by the pointer.
  - On grant, OP and IDX are registered, the matching ACK is pulsed, and the FSM moves to PULSE.
- PULSE: SBAR[idx]=0 for a set or RBAR[idx]=0 for a reset, for PULSE_CYCLES cycles. All other bits stay at 1.
- GAP: all SBAR and RBAR bits at 1 for GAP_CYCLES cycles.
- CHECK: one cycle. Q[idx] is sampled at the edge leaving CHECK, and ERR = (Q[idx] != OP).
- A command is always pulsed, even if the latch already holds the target value.
- Invariant: at most one bit across SBAR and RBAR is 0 in any cycle.
- Invariant: SBAR[i] and RBAR[i] are never 0 together.
- REQ inputs are ignored outside IDLE. OP and IDX changes after ACK have no effect.
- Counter width is sized for max(PULSE_CYCLES, GAP_CYCLES). The counter reloads on every state entry, with no wrap carry-over.
- Reset asserted mid-operation:
  - SBAR and RBAR go to all 1s asynchronously, BUSY goes to 0, and the command is dropped.
  - No DONE is produced for the dropped command.
  - Requesters re-issue after reset.

## Timing
- Let the grant edge end cycle 0, which is an IDLE cycle with REQ sampled high.
- ACK and the first drive cycle: ACK=1 and the pulse is driven in cycle 1.
- Pulse: driven in cycles 1..PULSE_CYCLES.
- Gap: cycles PULSE_CYCLES+1..PULSE_CYCLES+GAP_CYCLES.
- CHECK: cycle PULSE_CYCLES+GAP_CYCLES+1.
- DONE/ERR: high in cycle PULSE_CYCLES+GAP_CYCLES+2, which is an IDLE cycle. A new request can be granted at the end of that same cycle.
- Back-to-back grant interval: PULSE_CYCLES+GAP_CYCLES+2 cycles.
- Q is treated as settled because GAP_CYCLES ≥1 follows a registered drive. No synchronizer is used.

## Configuration
- Macro: SR_LATCH_CTRL_VERIFY_EN.
- With the macro defined: behaviour is as described above, including the CHECK state and ERR.
- Without the macro:
  - CHECK is removed: GAP goes to IDLE, and DONE is high in cycle PULSE_CYCLES+GAP_CYCLES+1.
  - ERR is tied to 0 and Q is unused.
  - Grant interval becomes PULSE_CYCLES+GAP_CYCLES+1.

## Test plan
All scenarios use N=8, PULSE_CYCLES=4, GAP_CYCLES=2, verify enabled, and behavioural NAND latch models on SBAR/RBAR/Q.
1. RSTBAR=0 for 3 cycles → SBAR=RBAR=8'hFF and ACK_A/ACK_B/DONE/ERR/BUSY all 0, checked from the asynchronous edge onward.
2. REQ_A=1, OP_A=1, IDX_A=3 →
   - ACK_A in cycle 1.
   - SBAR=8'hF7 in cycles 1–4, all 1s in cycles 5–6.
   - DONE=1 and ERR=0 in cycle 8; Q[3]=1.
3. REQ_A (set, idx 1) and REQ_B (reset, idx 1) raised together and held →
   - A is acked first, B is acked 8 cycles later.
   - Final Q[1]=0.
   - SBAR[1] and RBAR[1] are never both 0, and there are two DONE pulses, each with ERR=0.
4. Latch 5 modelled stuck at 0; set idx 5 → DONE with ERR=1 in cycle 8.
5. RSTBAR dropped in cycle 2 of a PULSE → SBAR returns to 8'hFF in the same cycle, BUSY=0, and no DONE follows after release.
6. REQ_B held high continuously with alternating OP → ACK_B every 8 cycles, and each DONE coincides with the IDLE cycle that precedes the next ACK.
